// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving one external 1-bit full adder, LSB-first.
// Define SERIAL_ADD_SUB_EN to add a 'sub' port for two's-complement subtraction.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  // Subtraction is a + ~b + 1, so only the load values change.
`ifdef SERIAL_ADD_SUB_EN
  assign b_ld = sub ? ~op_b : op_b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = op_b;
  assign c_ld = cin;
`endif

  assign fa_a   = busy & a_sh[0];
  assign fa_b   = busy & b_sh[0];
  assign fa_cin = busy & carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= op_a;
            b_sh   <= b_ld;
            carry  <= c_ld;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            state  <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          result <= {fa_sum, result[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            cout  <= fa_cout;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder.
// Define SERIAL_ADD_SUB_EN to also exercise subtraction.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] op_a, op_b;
  logic         ready, busy, done, cout;
  logic [W-1:0] result;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op, run it to completion and check the handshake timing.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] er, input logic ec);
    int early;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    step();                                   // E0
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready"}, ready, 0);
    early = 0;
    for (int i = 1; i < W; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b1) early++;
    end
    check({tag, "_run_hold"}, early, 0);
    step();                                   // E0+W
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, cout, ec);
    step();
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_ready_back"}, ready, 1);
  endtask

  initial begin
    int cnt_rdy, cnt_done;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    start = 1'b1;                             // rst wins over start
    step();
    check("rst_over_start", ready, 1);
    start = 1'b0; rst = 1'b0;
    step();

    run_op("t1", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // First RUN cycle presents bit 0 and carry-in to the adder.
    op_a = 8'h01; op_b = 8'h01; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("fa_first_bits", {fa_a, fa_b, fa_cin}, 3'b111);
    for (int i = 0; i < W + 1; i++) step();
    check("fa_idle_zero", {fa_a, fa_b, fa_cin}, 0);
    check("t_fa_result", result, 8'h03);

    // Start held high: second op only at first IDLE edge.
    op_a = 8'h3C; op_b = 8'h0F; cin = 1'b0; start = 1'b1;
    step();                                   // E0
    op_a = 8'h11; op_b = 8'h22;
    cnt_rdy = 0;
    for (int i = 1; i < W; i++) begin
      step();
      if (ready !== 1'b0) cnt_rdy++;
    end
    step();                                   // E0+8
    check("t4_ready_low", cnt_rdy + int'(ready), 0);
    check("t4_done", done, 1);
    check("t4_first_result", result, 8'h4B);
    step();                                   // E0+9: back in IDLE
    check("t4_idle", ready, 1);
    step();                                   // E0+10: accepted
    start = 1'b0;
    check("t4_accept2", busy, 1);
    for (int i = 0; i < W; i++) step();
    check("t4_done2", done, 1);
    check("t4_second_result", result, 8'h33);

    step();
    // Reset mid-RUN aborts and clears everything.
    op_a = 8'h3C; op_b = 8'h0F; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ready", ready, 1);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_result", result, 0);
    check("t5_cout", cout, 0);
    cnt_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (done !== 1'b0 || ready !== 1'b1) cnt_done++;
    end
    check("t5_no_done", cnt_done, 0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("t6a", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    run_op("t6b", 8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
    sub = 1'b0;
    run_op("t6c", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
